// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - classifies resolved instructions into BTB update/invalidate requests and drains them through a FIFO
// Optional BTBQ_PAIR_DRAIN_EN: pops an UPD/FLS pair with distinct BTB indices in one cycle.
module btb_update_queue #(
  parameter int DEPTH    = 4,
  parameter int IDX_BITS = 8,
  parameter int DROP_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res1_valid_i,
  input  logic [31:0]                res1_pc_i,
  input  logic                       res1_is_branch_i,
  input  logic                       res1_taken_i,
  input  logic [31:0]                res1_target_i,
  input  logic [2:0]                 res1_flags_i,
  input  logic                       res1_pred_hit_i,
  input  logic [31:0]                res1_pred_target_i,
  input  logic [2:0]                 res1_pred_flags_i,
  input  logic                       res2_valid_i,
  input  logic [31:0]                res2_pc_i,
  input  logic                       res2_is_branch_i,
  input  logic                       res2_taken_i,
  input  logic [31:0]                res2_target_i,
  input  logic [2:0]                 res2_flags_i,
  input  logic                       res2_pred_hit_i,
  input  logic [31:0]                res2_pred_target_i,
  input  logic [2:0]                 res2_pred_flags_i,
  input  logic                       queue_clr_i,
  output logic                       corr_valid_o,
  output logic [31:0]                corr_addr_o,
  output logic [31:0]                corr_branch_addr_o,
  output logic                       corr_uncondition_flag_o,
  output logic                       corr_link_flag_o,
  output logic                       corr_return_flag_o,
  output logic                       corr_fllush_valid_o,
  output logic [31:0]                corr_fllush_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] q_count_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
`ifdef BTBQ_PAIR_DRAIN_EN
  localparam bit PAIR_EN = 1'b1;
`else
  localparam bit PAIR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        upd;
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  flags;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [DROP_W-1:0] drop_cnt;

  logic          upd1, fls1, upd2, fls2, gen1, gen2;
  entry_t        ent1, ent2, ent_a, ent_b, h0, h1, u_ent;
  logic [1:0]    n_gen, n_push, n_drop, n_pop;
  logic [CW:0]   free;
  logic [DROP_W:0] drop_sum;
  logic          pair_ok, show_upd, show_fls;
  logic [31:0]   fls_pc;

  // Returns with matching flags skip target-only mismatches: the RAS owns their target.
  always_comb begin
    upd1 = res1_valid_i & res1_is_branch_i & res1_taken_i &
           (~res1_pred_hit_i | (res1_pred_flags_i != res1_flags_i) |
            ((res1_pred_target_i != res1_target_i) & ~res1_flags_i[0]));
    fls1 = res1_valid_i & ~res1_is_branch_i & res1_pred_hit_i;
    upd2 = res2_valid_i & res2_is_branch_i & res2_taken_i &
           (~res2_pred_hit_i | (res2_pred_flags_i != res2_flags_i) |
            ((res2_pred_target_i != res2_target_i) & ~res2_flags_i[0]));
    fls2 = res2_valid_i & ~res2_is_branch_i & res2_pred_hit_i;
    gen1 = upd1 | fls1;
    gen2 = upd2 | fls2;

    ent1    = '0;
    ent1.pc = res1_pc_i;
    if (upd1) begin
      ent1.upd    = 1'b1;
      ent1.target = res1_target_i;
      ent1.flags  = res1_flags_i;
    end
    ent2    = '0;
    ent2.pc = res2_pc_i;
    if (upd2) begin
      ent2.upd    = 1'b1;
      ent2.target = res2_target_i;
      ent2.flags  = res2_flags_i;
    end

    ent_a = gen1 ? ent1 : ent2;
    ent_b = ent2;
    n_gen = {1'b0, gen1} + {1'b0, gen2};
  end

  always_comb begin
    h0      = mem[rd_ptr];
    h1      = mem[rd_ptr + PW'(1)];
    pair_ok = PAIR_EN && (count >= CW'(2)) && (h0.upd != h1.upd) &&
              (h0.pc[IDX_BITS+1:2] != h1.pc[IDX_BITS+1:2]);
    n_pop   = (count == '0) ? 2'd0 : (pair_ok ? 2'd2 : 2'd1);
    free    = (CW+1)'(DEPTH) - {1'b0, count} + {{(CW-1){1'b0}}, n_pop};
    n_push  = (free >= {{(CW-1){1'b0}}, n_gen}) ? n_gen : free[1:0];
    n_drop  = n_gen - n_push;
    drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);

    // Without a pair, u_ent and the flush source both collapse onto the head.
    u_ent    = (pair_ok && !h0.upd) ? h1 : h0;
    fls_pc   = (pair_ok && h0.upd) ? h1.pc : h0.pc;
    show_upd = (count != '0) && u_ent.upd;
    show_fls = (count != '0) && (pair_ok || !h0.upd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (queue_clr_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr   <= rd_ptr + PW'(n_pop);
      wr_ptr   <= wr_ptr + PW'(n_push);
      count    <= count - CW'(n_pop) + CW'(n_push);
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  // Storage needs no reset: contents are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (!queue_clr_i && n_push != 2'd0) mem[wr_ptr] <= ent_a;
    if (!queue_clr_i && n_push == 2'd2) mem[wr_ptr + PW'(1)] <= ent_b;
  end

  always_comb begin
    corr_valid_o            = show_upd;
    corr_addr_o             = show_upd ? u_ent.pc : 32'h0;
    corr_branch_addr_o      = show_upd ? u_ent.target : 32'h0;
    corr_uncondition_flag_o = show_upd & u_ent.flags[2];
    corr_link_flag_o        = show_upd & u_ent.flags[1];
    corr_return_flag_o      = show_upd & u_ent.flags[0];
    corr_fllush_valid_o     = show_fls;
    corr_fllush_addr_o      = show_fls ? fls_pc : 32'h0;
    q_count_o               = count;
    drop_cnt_o              = drop_cnt;
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - vector table plus scoreboard bench for btb_update_queue
module tb_btb_update_queue;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_branch;
    logic        taken;
    logic [31:0] target;
    logic [2:0]  flags;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic [2:0]  pred_flags;
  } res_t;

  typedef struct packed {
    logic        upd;
    logic        fls;
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  flags;
  } req_t;

  typedef struct {
    res_t s1;
    res_t s2;
    req_t e1;
    req_t e2;
    int   cnt;
  } vec_t;

  localparam res_t IDLE = '0;
  localparam req_t RN   = '0;

  logic clk, rst;
  logic res1_valid_i, res1_is_branch_i, res1_taken_i, res1_pred_hit_i;
  logic [31:0] res1_pc_i, res1_target_i, res1_pred_target_i;
  logic [2:0] res1_flags_i, res1_pred_flags_i;
  logic res2_valid_i, res2_is_branch_i, res2_taken_i, res2_pred_hit_i;
  logic [31:0] res2_pc_i, res2_target_i, res2_pred_target_i;
  logic [2:0] res2_flags_i, res2_pred_flags_i;
  logic queue_clr_i;
  logic corr_valid_o, corr_uncondition_flag_o, corr_link_flag_o, corr_return_flag_o;
  logic [31:0] corr_addr_o, corr_branch_addr_o, corr_fllush_addr_o;
  logic corr_fllush_valid_o;
  logic [2:0] q_count_o;
  logic [15:0] drop_cnt_o;
  logic [100:0] out_v;

  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  req_t exp_q[$];
  req_t mon_r;
  vec_t vt[12];
  int   seq_cnt[4] = '{2, 3, 4, 4};

  btb_update_queue dut (
    .clk(clk), .rst(rst),
    .res1_valid_i(res1_valid_i), .res1_pc_i(res1_pc_i), .res1_is_branch_i(res1_is_branch_i),
    .res1_taken_i(res1_taken_i), .res1_target_i(res1_target_i), .res1_flags_i(res1_flags_i),
    .res1_pred_hit_i(res1_pred_hit_i), .res1_pred_target_i(res1_pred_target_i),
    .res1_pred_flags_i(res1_pred_flags_i),
    .res2_valid_i(res2_valid_i), .res2_pc_i(res2_pc_i), .res2_is_branch_i(res2_is_branch_i),
    .res2_taken_i(res2_taken_i), .res2_target_i(res2_target_i), .res2_flags_i(res2_flags_i),
    .res2_pred_hit_i(res2_pred_hit_i), .res2_pred_target_i(res2_pred_target_i),
    .res2_pred_flags_i(res2_pred_flags_i),
    .queue_clr_i(queue_clr_i),
    .corr_valid_o(corr_valid_o), .corr_addr_o(corr_addr_o), .corr_branch_addr_o(corr_branch_addr_o),
    .corr_uncondition_flag_o(corr_uncondition_flag_o), .corr_link_flag_o(corr_link_flag_o),
    .corr_return_flag_o(corr_return_flag_o), .corr_fllush_valid_o(corr_fllush_valid_o),
    .corr_fllush_addr_o(corr_fllush_addr_o), .q_count_o(q_count_o), .drop_cnt_o(drop_cnt_o)
  );

  assign out_v = {corr_valid_o, corr_addr_o, corr_branch_addr_o, corr_uncondition_flag_o,
                  corr_link_flag_o, corr_return_flag_o, corr_fllush_valid_o, corr_fllush_addr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t br(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] fl,
                              input logic tk, input logic ph, input logic [31:0] ptgt,
                              input logic [2:0] pfl);
    res_t r;
    r = '{valid: 1'b1, pc: pc, is_branch: 1'b1, taken: tk, target: tgt, flags: fl,
          pred_hit: ph, pred_target: ptgt, pred_flags: pfl};
    return r;
  endfunction

  function automatic res_t nb(input logic [31:0] pc, input logic ph);
    res_t r;
    r = '{valid: 1'b1, pc: pc, is_branch: 1'b0, taken: 1'b0, target: 32'hDEADBEEF, flags: 3'b111,
          pred_hit: ph, pred_target: 32'h12345678, pred_flags: 3'b101};
    return r;
  endfunction

  function automatic res_t inv(input res_t r);
    res_t x;
    x = r;
    x.valid = 1'b0;
    return x;
  endfunction

  function automatic req_t ru(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] fl);
    req_t q;
    q = '{upd: 1'b1, fls: 1'b0, pc: pc, target: tgt, flags: fl};
    return q;
  endfunction

  function automatic req_t rf(input logic [31:0] pc);
    req_t q;
    q = '{upd: 1'b0, fls: 1'b1, pc: pc, target: 32'h0, flags: 3'b000};
    return q;
  endfunction

  function automatic logic [100:0] req_vec(input req_t r);
    if (r.upd) return {1'b1, r.pc, r.target, r.flags, 1'b0, 32'h0};
    if (r.fls) return {1'b0, 32'h0, 32'h0, 3'b000, 1'b1, r.pc};
    return '0;
  endfunction

  task automatic check_v(input string name, input logic [100:0] act, input logic [100:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input res_t a, input res_t b, input logic clr);
    res1_valid_i = a.valid; res1_pc_i = a.pc; res1_is_branch_i = a.is_branch;
    res1_taken_i = a.taken; res1_target_i = a.target; res1_flags_i = a.flags;
    res1_pred_hit_i = a.pred_hit; res1_pred_target_i = a.pred_target; res1_pred_flags_i = a.pred_flags;
    res2_valid_i = b.valid; res2_pc_i = b.pc; res2_is_branch_i = b.is_branch;
    res2_taken_i = b.taken; res2_target_i = b.target; res2_flags_i = b.flags;
    res2_pred_hit_i = b.pred_hit; res2_pred_target_i = b.pred_target; res2_pred_flags_i = b.pred_flags;
    queue_clr_i = clr;
  endtask

  task automatic step(input res_t a, input res_t b, input logic clr);
    drive(a, b, clr);
    @(posedge clk);
    #1;
    drive(IDLE, IDLE, 1'b0);
  endtask

  task automatic push_exp(input req_t r);
    if (r.upd || r.fls) exp_q.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(IDLE, IDLE, 1'b0);
  endtask

  // Every presented request must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && (corr_valid_o || corr_fllush_valid_o)) begin
      if (exp_q.size() == 0) begin
        check_v("unexpected_req", out_v, '0);
      end else begin
        mon_r = exp_q.pop_front();
        check_v("drain_req", out_v, req_vec(mon_r));
      end
    end
  end

  initial begin
    vt[0]  = '{s1: br(32'h1C000010, 32'h1C000100, 3'b100, 1, 0, 32'h0, 3'b000), s2: IDLE,
               e1: ru(32'h1C000010, 32'h1C000100, 3'b100), e2: RN, cnt: 1};
    vt[1]  = '{s1: nb(32'h1C000020, 1), s2: IDLE, e1: rf(32'h1C000020), e2: RN, cnt: 1};
    vt[2]  = '{s1: br(32'h1C000030, 32'h1C000400, 3'b001, 1, 1, 32'h1C000500, 3'b001), s2: IDLE,
               e1: RN, e2: RN, cnt: 0};
    vt[3]  = '{s1: br(32'h1C000034, 32'h1C000600, 3'b000, 0, 1, 32'h1C000600, 3'b000), s2: IDLE,
               e1: RN, e2: RN, cnt: 0};
    vt[4]  = '{s1: br(32'h1C000038, 32'h1C000700, 3'b010, 1, 1, 32'h1C000700, 3'b010), s2: IDLE,
               e1: RN, e2: RN, cnt: 0};
    vt[5]  = '{s1: br(32'h1C00003C, 32'h1C000800, 3'b010, 1, 1, 32'h1C000800, 3'b000), s2: IDLE,
               e1: ru(32'h1C00003C, 32'h1C000800, 3'b010), e2: RN, cnt: 1};
    vt[6]  = '{s1: br(32'h1C000044, 32'h1C000900, 3'b000, 1, 1, 32'h1C000990, 3'b000), s2: IDLE,
               e1: ru(32'h1C000044, 32'h1C000900, 3'b000), e2: RN, cnt: 1};
    vt[7]  = '{s1: br(32'h1C000048, 32'h1C000A00, 3'b001, 1, 1, 32'h1C000B00, 3'b000), s2: IDLE,
               e1: ru(32'h1C000048, 32'h1C000A00, 3'b001), e2: RN, cnt: 1};
    vt[8]  = '{s1: nb(32'h1C00004C, 0), s2: IDLE, e1: RN, e2: RN, cnt: 0};
    vt[9]  = '{s1: inv(br(32'h1C000054, 32'h1C000E00, 3'b100, 1, 0, 32'h0, 3'b000)), s2: IDLE,
               e1: RN, e2: RN, cnt: 0};
    vt[10] = '{s1: nb(32'h1C000060, 1), s2: br(32'h1C000060, 32'h1C000C00, 3'b100, 1, 0, 32'h0, 3'b000),
               e1: rf(32'h1C000060), e2: ru(32'h1C000060, 32'h1C000C00, 3'b100), cnt: 2};
    vt[11] = '{s1: IDLE, s2: br(32'h1C000070, 32'h1C000D00, 3'b110, 1, 1, 32'h1C000D00, 3'b100),
               e1: ru(32'h1C000070, 32'h1C000D00, 3'b110), e2: RN, cnt: 1};

    rst = 1'b0;
    drive(IDLE, IDLE, 1'b0);
    #12;
    check_v("reset_outputs", out_v, '0);
    check_i("reset_count", int'(q_count_o), 0);
    check_i("reset_drop", int'(drop_cnt_o), 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      push_exp(vt[i].e1);
      push_exp(vt[i].e2);
      step(vt[i].s1, vt[i].s2, 1'b0);
      check_i($sformatf("vec%0d_count", i), int'(q_count_o), vt[i].cnt);
      idle(3);
      check_v($sformatf("vec%0d_idle_out", i), out_v, '0);
      check_i($sformatf("vec%0d_drained", i), int'(q_count_o), 0);
    end

    // Four dual-UPD cycles into a 4-deep queue: the last slot-2 request is dropped.
    for (int k = 0; k < 4; k++) begin
      push_exp(ru(32'h1C001000 + 32'(k * 16), 32'h1C002000 + 32'(k * 16), 3'b100));
      if (k < 3) push_exp(ru(32'h1C001008 + 32'(k * 16), 32'h1C002008 + 32'(k * 16), 3'b010));
      step(br(32'h1C001000 + 32'(k * 16), 32'h1C002000 + 32'(k * 16), 3'b100, 1, 0, 32'h0, 3'b000),
           br(32'h1C001008 + 32'(k * 16), 32'h1C002008 + 32'(k * 16), 3'b010, 1, 0, 32'h0, 3'b000),
           1'b0);
      check_i($sformatf("fill%0d_count", k), int'(q_count_o), seq_cnt[k]);
    end
    check_i("fill_drop", int'(drop_cnt_o), 1);
    idle(6);
    check_i("fill_drained", int'(q_count_o), 0);

    // Clear with a concurrent dual UPD: nothing kept, nothing counted as dropped.
    push_exp(ru(32'h1C003000, 32'h1C004000, 3'b100));
    push_exp(ru(32'h1C003004, 32'h1C004004, 3'b100));
    step(br(32'h1C003000, 32'h1C004000, 3'b100, 1, 0, 32'h0, 3'b000),
         br(32'h1C003004, 32'h1C004004, 3'b100, 1, 0, 32'h0, 3'b000), 1'b0);
    check_i("clr_pre_count2", int'(q_count_o), 2);
    step(br(32'h1C003010, 32'h1C004010, 3'b100, 1, 0, 32'h0, 3'b000),
         br(32'h1C003014, 32'h1C004014, 3'b100, 1, 0, 32'h0, 3'b000), 1'b0);
    check_i("clr_pre_count3", int'(q_count_o), 3);
    step(br(32'h1C003020, 32'h1C004020, 3'b100, 1, 0, 32'h0, 3'b000),
         br(32'h1C003024, 32'h1C004024, 3'b100, 1, 0, 32'h0, 3'b000), 1'b1);
    check_i("clr_count", int'(q_count_o), 0);
    check_v("clr_outputs", out_v, '0);
    check_i("clr_drop", int'(drop_cnt_o), 1);
    idle(3);
    check_i("sb_empty", exp_q.size(), 0);

`ifdef BTBQ_PAIR_DRAIN_EN
    mon_en = 1'b0;
    step(br(32'h00000100, 32'h00000800, 3'b100, 1, 0, 32'h0, 3'b000), nb(32'h00000204, 1), 1'b0);
    check_v("pair_drain", {corr_valid_o, corr_addr_o, 36'h0, corr_fllush_valid_o, corr_fllush_addr_o},
            {1'b1, 32'h00000100, 36'h0, 1'b1, 32'h00000204});
    idle(2);
    check_i("pair_drained", int'(q_count_o), 0);
`endif

    // Asynchronous reset between edges while the queue is draining.
    mon_en = 1'b0;
    step(br(32'h1C005000, 32'h1C006000, 3'b100, 1, 0, 32'h0, 3'b000),
         br(32'h1C005004, 32'h1C006004, 3'b100, 1, 0, 32'h0, 3'b000), 1'b0);
    check_i("rst_pre_count", int'(q_count_o), 2);
    #2;
    rst = 1'b0;
    #1;
    check_i("rst_async_valid", int'({corr_valid_o, corr_fllush_valid_o}), 0);
    check_i("rst_async_count", int'(q_count_o), 0);
    check_i("rst_async_drop", int'(drop_cnt_o), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_v("post_rst_outputs", out_v, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Producer side of the BTB correction interface.
- Takes up to two resolved instructions per cycle from the dual-issue commit stage and classifies each one as a BTB update, a BTB invalidate, or no action.
- Buffers the resulting requests in a small FIFO and drains them into the BTB's single correct port and single flush port.
- Sits between commit/branch-resolve and the BTB in IF.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- IDX_BITS, 8: BTB index width; index = addr[IDX_BITS+1:2]. Used only by the optional pair drain.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- res1_valid_i  in  1  slot 1 (older) resolved instruction valid
- res1_pc_i  in  32  slot 1 PC
- res1_is_branch_i  in  1  slot 1 is a branch/jump
- res1_taken_i  in  1  slot 1 actually taken
- res1_target_i  in  32  slot 1 actual target
- res1_flags_i  in  3  slot 1 actual {uncond, link, return}
- res1_pred_hit_i  in  1  BTB search_found seen at fetch for slot 1
- res1_pred_target_i  in  32  BTB branch_addr seen at fetch for slot 1
- res1_pred_flags_i  in  3  BTB {uncond, link, return} seen at fetch for slot 1
- res2_*  in  as res1_*  slot 2 (younger), same meanings
- queue_clr_i  in  1  discard all pending requests
- corr_valid_o  out  1  update request
- corr_addr_o  out  32  update PC
- corr_branch_addr_o  out  32  update target
- corr_uncondition_flag_o  out  1  update uncond flag
- corr_link_flag_o  out  1  update link flag
- corr_return_flag_o  out  1  update return flag
- corr_fllush_valid_o  out  1  invalidate request
- corr_fllush_addr_o  out  32  invalidate PC
- q_count_o  out  $clog2(DEPTH+1)  current occupancy
- drop_cnt_o  out  DROP_W  saturating count of dropped requests

Behaviour:
- Reset (rst=0, asynchronous): pointers, count and drop_cnt clear to 0; all outputs read 0 immediately, with no clock edge required.
- Classification, per slot, purely combinational from that slot's inputs:
  - UPD when valid & is_branch & taken & (!pred_hit | pred_flags≠flags | (pred_target≠target & !flags[0])).
  - A return whose flags match is not updated on a target mismatch alone; the RAS supplies the target.
  - FLS when valid & !is_branch & pred_hit (aliased entry).
  - Otherwise no entry. Not-taken conditional branches never generate an entry.
- Entry contents: {type, pc, target, flags}. FLS entries carry pc only; other fields are 0.
- Enqueue:
  - n = number of entries generated this cycle (0–2).
  - free = DEPTH − count + pop, so push and pop in the same cycle are legal.
  - When both slots enqueue, slot 1 is written before slot 2.
  - free ≥ n: push all.
  - free = 1 and n = 2: push slot 1, drop slot 2.
  - free = 0: drop all.
  - drop_cnt increases by the number dropped and saturates at all-ones.
- Drain:
  - The BTB has no ready signal; when count > 0, the head is popped every cycle.
  - UPD head drives corr_valid_o=1 and the corr_* fields. FLS head drives corr_fllush_valid_o=1 and corr_fllush_addr_o.
  - All non-asserted request fields read 0. An empty queue drives all outputs 0.
  - Outputs come only from queue registers; there is no combinational path from res*_i.
- Latency: a request enqueued at edge N is presented in the cycle after N at the earliest, when the queue was empty.
- queue_clr_i: at the next edge, count := 0 and pointers := 0. Same-cycle new entries are discarded and are not counted as drops. The current head is still presented this cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

Optional Feature:
- BTBQ_PAIR_DRAIN_EN defined:
  - If count ≥ 2, head and head+1 have different types, and their index bits differ, both are popped in one cycle.
  - The UPD entry drives corr_*, the FLS entry drives corr_fllush_*, and free counts pop = 2.
- Not defined: at most one pop per cycle; corr_valid_o and corr_fllush_valid_o are never high together.

Test Plan:
- Empty queue; slot 1 valid, branch, taken, pc=0x1C000010, target=0x1C000100, flags=100, pred_hit=0 → next cycle: corr_valid_o=1, corr_addr_o=0x1C000010, corr_branch_addr_o=0x1C000100, uncond=1, link=0, return=0. Cycle after: all outputs 0.
- Slot 1 non-branch, pc=0x1C000020, pred_hit=1 → next cycle: corr_fllush_valid_o=1, corr_fllush_addr_o=0x1C000020, corr_valid_o=0.
- Four consecutive cycles of dual UPD, DEPTH=4 → q_count_o goes 2, 3, 4, 4. The fourth cycle's slot-2 entry is dropped, drop_cnt_o=1. Drained addresses appear in slot1/slot2 program order.
- Return with pred_hit=1, flags=001 both predicted and actual, target mismatch → no entry; q_count_o stays 0.
- q_count_o=3 with queue_clr_i=1 and a concurrent dual UPD → next cycle: q_count_o=0, all valids 0, drop_cnt_o unchanged.
- Assert rst=0 mid-drain between clock edges → corr_valid_o, corr_fllush_valid_o, q_count_o and drop_cnt_o read 0 before the next edge. With BTBQ_PAIR_DRAIN_EN: queue holding UPD 0x100 then FLS 0x204 → both valids high in the same cycle.
